// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for the LCD timing controller.
//   - lcd_state_e : power/sequence state of the controller
//   - RGB_W       : RGB565 pixel width
//   - COORD_W     : scan counter and coordinate width
//   - DEF_*       : default 480x272 panel timing
//   - SYNC_IDLE   : idle value of the {hs, vs, de} bundle
package lcd_timing_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WARMUP = 2'd1,
        ST_ON     = 2'd2,
        ST_DRAIN  = 2'd3
    } lcd_state_e;

    localparam int RGB_W   = 16;
    localparam int COORD_W = 11;

    localparam int DEF_H_SYNC  = 41;
    localparam int DEF_H_BACK  = 2;
    localparam int DEF_H_DISP  = 480;
    localparam int DEF_H_FRONT = 2;
    localparam int DEF_V_SYNC  = 10;
    localparam int DEF_V_BACK  = 2;
    localparam int DEF_V_DISP  = 272;
    localparam int DEF_V_FRONT = 2;

    // {hs, vs, de}: syncs are active low, so idle is high/high/low.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

endpackage

// File: rtl/lcd_delay_line.sv
// DATA_LAT-deep register pipeline for the {hs, vs, de} bundle, so the panel
// sync/enable pins line up with pixel data returned by the pixel generator.
// Ports:
//   lcd_clk - pixel clock
//   sys_rst - asynchronous active-high reset (pipeline loads SYNC_IDLE)
//   sync_i  - {hs, vs, de} from the scan stage
//   sync_o  - {hs, vs, de} delayed by DATA_LAT clocks
module lcd_delay_line
    import lcd_timing_pkg::*;
#(
    parameter int DATA_LAT = 1
) (
    input  logic       lcd_clk,
    input  logic       sys_rst,
    input  logic [2:0] sync_i,
    output logic [2:0] sync_o
);

    logic [3*DATA_LAT-1:0] sr_q;

    if (DATA_LAT == 1) begin : g_one
        always_ff @(posedge lcd_clk or posedge sys_rst) begin
            if (sys_rst) sr_q <= SYNC_IDLE;
            else         sr_q <= sync_i;
        end
    end else begin : g_multi
        always_ff @(posedge lcd_clk or posedge sys_rst) begin
            if (sys_rst) sr_q <= {DATA_LAT{SYNC_IDLE}};
            else         sr_q <= {sr_q[3*DATA_LAT-4:0], sync_i};
        end
    end

    assign sync_o = sr_q[3*DATA_LAT-1 -: 3];

endmodule

// File: rtl/lcd_timing_ctrl.sv
// LCD scan timing and power sequencer. Runs the H/V scan counters, issues
// pixel request coordinates DATA_LAT clocks ahead of lcd_de, and sequences
// the backlight (settle frames before turn-on, end-of-frame shutdown).
//
// state  | meaning
// -------+------------------------------------------------------------
// OFF    | counters held at 0, panel pins idle
// WARMUP | timing runs, backlight off, counting settle frames
// ON     | timing runs, backlight on, pixel data driven to the panel
// DRAIN  | backlight off, scan finishes the current frame
//
// Ports:
//   lcd_clk     - pixel clock
//   sys_rst     - asynchronous active-high reset
//   disp_en     - level request to run the display
//   pixel_data  - RGB565 from the pixel generator, DATA_LAT after coordinate
//   pixel_xpos  - requested column 1..H_DISP, 0 outside the request window
//   pixel_ypos  - requested row 1..V_DISP, 0 outside the request window
//   lcd_hs/vs   - panel syncs, active low
//   lcd_de      - panel data enable
//   lcd_rgb     - pixel to panel (0 unless lcd_de and lcd_bl)
//   lcd_bl      - backlight enable
//   frame_start - one-cycle pulse when the panel-side scan is at (0,0)
module lcd_timing_ctrl
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int H_DISP          = DEF_H_DISP,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BACK          = DEF_V_BACK,
    parameter int V_DISP          = DEF_V_DISP,
    parameter int V_FRONT         = DEF_V_FRONT,
    parameter int DATA_LAT        = 1,
    parameter int BL_DELAY_FRAMES = 2
) (
    input  logic               lcd_clk,
    input  logic               sys_rst,
    input  logic               disp_en,
    input  logic [RGB_W-1:0]   pixel_data,
    output logic [COORD_W-1:0] pixel_xpos,
    output logic [COORD_W-1:0] pixel_ypos,
    output logic               lcd_hs,
    output logic               lcd_vs,
    output logic               lcd_de,
    output logic [RGB_W-1:0]   lcd_rgb,
    output logic               lcd_bl,
    output logic               frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_ACT0  = H_SYNC + H_BACK;
    localparam int V_ACT0  = V_SYNC + V_BACK;

    if (H_TOTAL > 2047) begin : g_chk_htotal
        $error("lcd_timing_ctrl: H_TOTAL exceeds 11-bit counter range");
    end
    if (V_TOTAL > 2047) begin : g_chk_vtotal
        $error("lcd_timing_ctrl: V_TOTAL exceeds 11-bit counter range");
    end
    if (DATA_LAT < 1 || DATA_LAT > 4) begin : g_chk_lat
        $error("lcd_timing_ctrl: DATA_LAT must be 1..4");
    end
    if (BL_DELAY_FRAMES < 0 || BL_DELAY_FRAMES > 255) begin : g_chk_bl
        $error("lcd_timing_ctrl: BL_DELAY_FRAMES must be 0..255");
    end

    lcd_state_e         state_q, state_d;
    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic [7:0]         frm_q, frm_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [2:0]         sync_q, sync_d;
    logic [DATA_LAT:0]  fs_sr_q;
    logic               bl_q, bl_d;
    logic               running, h_last, v_last, frame_wrap, win, fs_raw;
    logic [2:0]         sync_aligned;

    assign running    = (state_q != ST_OFF);
    assign h_last     = (h_q == COORD_W'(H_TOTAL - 1));
    assign v_last     = (v_q == COORD_W'(V_TOTAL - 1));
    assign frame_wrap = h_last && v_last;

    always_comb begin
        state_d = state_q;
        frm_d   = frm_q;
        case (state_q)
            ST_OFF: begin
                frm_d = '0;
                if (disp_en) state_d = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (frame_wrap) frm_d = frm_q + 8'd1;
                if (!disp_en)                              state_d = ST_DRAIN;
                else if (frm_q >= 8'(BL_DELAY_FRAMES))     state_d = ST_ON;
            end
            ST_ON: begin
                if (!disp_en) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (frame_wrap) begin
                    state_d = disp_en ? ST_WARMUP : ST_OFF;
                    frm_d   = '0;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_comb begin
        h_d = '0;
        v_d = '0;
        if (running) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
                v_d = v_q;
            end
        end
    end

    // Scan stage: coordinates and the un-delayed {hs, vs, de} come from the
    // same counter value; the delay line then shifts the panel pins by
    // DATA_LAT so they meet the returning pixel_data.
    always_comb begin
        win = running
              && (h_q >= COORD_W'(H_ACT0)) && (h_q < COORD_W'(H_ACT0 + H_DISP))
              && (v_q >= COORD_W'(V_ACT0)) && (v_q < COORD_W'(V_ACT0 + V_DISP));
        x_d    = win ? h_q - COORD_W'(H_ACT0) + 1'b1 : '0;
        y_d    = win ? v_q - COORD_W'(V_ACT0) + 1'b1 : '0;
        sync_d = running ? {h_q >= COORD_W'(H_SYNC), v_q >= COORD_W'(V_SYNC), win}
                         : SYNC_IDLE;
        fs_raw = running && (h_q == '0) && (v_q == '0);
    end

    // Backlight rises together with the aligned frame_start once ON, and
    // falls the cycle after the state leaves ON.
    assign lcd_bl = bl_q | (frame_start && (state_q == ST_ON));
    assign bl_d   = (state_d == ST_ON) && lcd_bl;

    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_OFF;
            h_q     <= '0;
            v_q     <= '0;
            frm_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sync_q  <= SYNC_IDLE;
            fs_sr_q <= '0;
            bl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frm_q   <= frm_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sync_q  <= sync_d;
            fs_sr_q <= {fs_sr_q[DATA_LAT-1:0], fs_raw};
            bl_q    <= bl_d;
        end
    end

    lcd_delay_line #(
        .DATA_LAT (DATA_LAT)
    ) u_delay (
        .lcd_clk (lcd_clk),
        .sys_rst (sys_rst),
        .sync_i  (sync_q),
        .sync_o  (sync_aligned)
    );

    assign {lcd_hs, lcd_vs, lcd_de} = sync_aligned;
    assign frame_start = fs_sr_q[DATA_LAT];
    assign pixel_xpos  = x_q;
    assign pixel_ypos  = y_q;
    assign lcd_rgb     = (lcd_de && lcd_bl) ? pixel_data : '0;

endmodule
